gcm_core_share_scheduler: RTL and testbench

- Shares one GCM_AE_HW_1x1 authenticated-encryption core between NUM_REQ requester channels using round-robin arbitration.
- Sequences the core's ap_start/ap_ready/ap_done handshake for the granted channel.
- Watches the core's deadlock-monitor block flag and a run-time watchdog. On a stall it aborts the job, pulses a core soft reset and reports the error, so one hung channel cannot starve the others.
- Sits between the per-channel DMA front-ends and the crypto core.

---
 rtl/gcm_core_share_scheduler.sv | 162 ++++++++++++++++
 tb/tb_gcm_core_share_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_core_share_scheduler.sv
// gcm_core_share_scheduler
// Shares one GCM_AE_HW_1x1 core among NUM_REQ requesters using round-robin
// arbitration. It drives the ap_start/ap_ready/ap_done handshake for the owner.
// A stalled job (deadlock-monitor block or run-time watchdog) is aborted with a
// core soft reset, so one hung channel cannot starve the others.
module gcm_core_share_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int BLOCK_HOLD     = 16,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] chan_done,
    output logic [NUM_REQ-1:0] chan_err,
    output logic               core_start,
    input  logic               core_ready,
    input  logic               core_done,
    input  logic               core_idle,
    input  logic               core_block,
    output logic               core_rst_req,
    output logic [1:0]         err_cause,
    output logic               busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES);
    localparam int BLK_W = $clog2(BLOCK_HOLD);
    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLOCK_HOLD - 1);
    localparam logic [REC_W-1:0] REC_LAST  = REC_W'(RECOVER_CYCLES);

    localparam logic [1:0] CAUSE_DEADLOCK = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {IDLE, START, RUN, DONE, RECOVER} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] pick;
    logic [RUN_W-1:0]   run_cnt;
    logic [BLK_W-1:0]   blk_cnt;
    logic [REC_W-1:0]   rec_cnt;
    logic               blk_trip;
    logic               run_trip;

    assign blk_trip = core_block && (blk_cnt == BLK_LAST);
    assign run_trip = (run_cnt == RUN_LAST);
    assign rr_next  = (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);

    // Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W:0] slot;
        logic           found;
        // NOTE: every combinational output gets a default first; a path that
        // leaves a variable unassigned would otherwise infer a latch.
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (slot >= NUM_REQ_W) slot = slot - NUM_REQ_W;
            if (!found && req[slot[PTR_W-1:0]]) begin
                pick[slot[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    // Binary index of the current owner, used to advance the round-robin pointer.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner_idx = PTR_W'(i);
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next   = state;
        core_start   = 1'b0;
        core_rst_req = 1'b0;
        chan_done    = '0;
        chan_err     = '0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) state_next = START;
            end
            START: begin
                core_start = 1'b1;
                if (core_ready) state_next = core_done ? DONE : RUN;
            end
            RUN: begin
                // Completion wins over deadlock, and deadlock wins over timeout.
                if (core_done)     state_next = DONE;
                else if (blk_trip) state_next = RECOVER;
                else if (run_trip) state_next = RECOVER;
            end
            DONE: begin
                chan_done  = grant;
                state_next = IDLE;
            end
            RECOVER: begin
                core_rst_req = (rec_cnt != REC_LAST);
                if (rec_cnt == '0) chan_err = grant;
                if (rec_cnt == REC_LAST && core_idle) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, grant ownership, fairness pointer and sticky abort cause.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: registers use non-blocking assignments so each one samples
            // pre-edge values regardless of statement order in the block.
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            err_cause <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (|req)) grant <= pick;
            if ((state == DONE) || (state == RECOVER && state_next == IDLE)) begin
                grant  <= '0;
                rr_ptr <= rr_next;
            end
            if (state == RUN && state_next == RECOVER)
                err_cause <= blk_trip ? CAUSE_DEADLOCK : CAUSE_TIMEOUT;
        end
    end

    // Saturating job counters; they sit at zero outside RUN/RECOVER, so they
    // are already cleared when a job enters START.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_cnt <= '0;
            blk_cnt <= '0;
            rec_cnt <= '0;
        end else begin
            if (state == RUN) begin
                if (!(&run_cnt)) run_cnt <= run_cnt + RUN_W'(1);
                if (!core_block)       blk_cnt <= '0;
                else if (!(&blk_cnt))  blk_cnt <= blk_cnt + BLK_W'(1);
            end else begin
                run_cnt <= '0;
                blk_cnt <= '0;
            end
            if (state != RECOVER)       rec_cnt <= '0;
            else if (rec_cnt != REC_LAST) rec_cnt <= rec_cnt + REC_W'(1);
        end
    end

endmodule

// File: tb/tb_gcm_core_share_scheduler.sv
// Directed testbench for gcm_core_share_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=64).
module tb_gcm_core_share_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] chan_done;
    logic [3:0] chan_err;
    logic       core_start;
    logic       core_ready;
    logic       core_done;
    logic       core_idle;
    logic       core_block;
    logic       core_rst_req;
    logic [1:0] err_cause;
    logic       busy;

    int total = 0;
    int bad   = 0;

    gcm_core_share_scheduler #(
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(64),
        .BLOCK_HOLD    (16),
        .RECOVER_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .chan_done   (chan_done),
        .chan_err    (chan_err),
        .core_start  (core_start),
        .core_ready  (core_ready),
        .core_done   (core_done),
        .core_idle   (core_idle),
        .core_block  (core_block),
        .core_rst_req(core_rst_req),
        .err_cause   (err_cause),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Compare the whole output vector {grant, chan_done, chan_err, core_start,
    // core_rst_req, err_cause, busy} against hand-computed values.
    task automatic exp_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] e, input logic s, input logic r,
                           input logic [1:0] c, input logic b);
        logic [16:0] got;
        logic [16:0] want;
        got  = {grant, chan_done, chan_err, core_start, core_rst_req, err_cause, busy};
        want = {g, d, e, s, r, c, b};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, got, want);
        end
    endtask

    // One normal job for the channel expected to win: START, ready, n RUN cycles, DONE.
    task automatic rr_job(input logic [3:0] g, input int n, input logic [1:0] c);
        cyc();
        exp_out("rr_start", g, 4'b0, 4'b0, 1'b1, 1'b0, c, 1'b1);
        core_ready = 1'b1;
        cyc();
        exp_out("rr_run", g, 4'b0, 4'b0, 1'b0, 1'b0, c, 1'b1);
        core_ready = 1'b0;
        repeat (n - 1) cyc();
        core_done = 1'b1;
        cyc();
        exp_out("rr_done", g, g, 4'b0, 1'b0, 1'b0, c, 1'b1);
        core_done = 1'b0;
        cyc();
        exp_out("rr_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, c, 1'b0);
    endtask

    // Structural invariants on every cycle outside reset.
    always @(negedge clock) begin
        if (!reset) begin
            total++;
            assert ($onehot0(grant) && !((|chan_done) && (|chan_err)) &&
                    !(core_start && core_rst_req)) else begin
                bad++;
                $error("FAIL invariant: grant=%b done=%b err=%b start=%b rst=%b expected onehot0/exclusive",
                       grant, chan_done, chan_err, core_start, core_rst_req);
            end
        end
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "time limit");
    end

    initial begin
        reset      = 1'b1;
        req        = 4'b0;
        core_ready = 1'b0;
        core_done  = 1'b0;
        core_idle  = 1'b1;
        core_block = 1'b0;

        // Reset state
        cyc();
        cyc();
        exp_out("reset", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        cyc();
        exp_out("idle_no_req", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Single job: ready on the 2nd START cycle, done 10 cycles later
        req = 4'b0001;
        cyc();
        exp_out("t1_grant", 4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        cyc();
        exp_out("t1_start2", 4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b1;
        cyc();
        exp_out("t1_run", 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b0;
        repeat (9) cyc();
        exp_out("t1_run10", 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        core_done = 1'b1;
        cyc();
        exp_out("t1_done", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        core_done = 1'b0;
        req       = 4'b0;
        cyc();
        exp_out("t1_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset so the round-robin pointer starts from channel 0
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // Round-robin: all four channels requesting, eight jobs
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            logic [3:0] g;
            g = 4'b0001 << (j % 4);
            rr_job(g, 5, 2'b00);
        end

        // Deadlock on channel 2; channel 3 also requesting
        req = 4'b1100;
        cyc();
        exp_out("dl_start", 4'b0100, 4'b0, 4'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        core_block = 1'b1;
        core_idle  = 1'b0;
        repeat (15) cyc();
        exp_out("dl_blk16", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        cyc();
        exp_out("dl_err", 4'b0100, 4'b0, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b1);
        core_block = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            exp_out("dl_rst_hold", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b1, 2'b01, 1'b1);
        end
        cyc();
        exp_out("dl_rst_end", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        cyc();
        exp_out("dl_wait_idle", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_idle = 1'b1;
        cyc();
        exp_out("dl_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        cyc();
        exp_out("dl_next_ch3", 4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 2'b01, 1'b1);

        // Ready and done in the same START cycle go straight to DONE
        core_ready = 1'b1;
        core_done  = 1'b1;
        cyc();
        exp_out("same_cycle_done", 4'b1000, 4'b1000, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_ready = 1'b0;
        core_done  = 1'b0;
        req        = 4'b0;
        cyc();
        exp_out("same_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // Block glitch: 15 high, 1 low, 15 high, then done -> no abort
        req = 4'b0001;
        cyc();
        exp_out("gl_start", 4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        core_block = 1'b1;
        repeat (15) cyc();
        core_block = 1'b0;
        cyc();
        exp_out("gl_mid", 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_block = 1'b1;
        repeat (15) cyc();
        exp_out("gl_run", 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_block = 1'b0;
        core_done  = 1'b1;
        cyc();
        exp_out("gl_done", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_done = 1'b0;
        req       = 4'b0;
        cyc();
        exp_out("gl_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // Done on the 16th block cycle wins over deadlock
        req = 4'b0010;
        cyc();
        exp_out("db_start", 4'b0010, 4'b0, 4'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        core_block = 1'b1;
        repeat (15) cyc();
        core_done = 1'b1;
        cyc();
        exp_out("db_done", 4'b0010, 4'b0010, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        core_done  = 1'b0;
        core_block = 1'b0;
        req        = 4'b0;
        cyc();
        exp_out("db_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b0);

        // Timeout after 64 RUN cycles
        req = 4'b0100;
        cyc();
        exp_out("to_start", 4'b0100, 4'b0, 4'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        repeat (63) cyc();
        exp_out("to_run64", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        cyc();
        exp_out("to_err", 4'b0100, 4'b0, 4'b0100, 1'b0, 1'b1, 2'b10, 1'b1);
        req = 4'b0;
        repeat (4) cyc();
        exp_out("to_rst_end", 4'b0100, 4'b0, 4'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        cyc();
        exp_out("to_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b10, 1'b0);

        // Reset in RUN drops the job silently
        req = 4'b1000;
        cyc();
        exp_out("rs_start", 4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 2'b10, 1'b1);
        core_ready = 1'b1;
        cyc();
        core_ready = 1'b0;
        cyc();
        exp_out("rs_run", 4'b1000, 4'b0, 4'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        reset = 1'b1;
        cyc();
        exp_out("rs_reset", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        req   = 4'b0;
        cyc();
        exp_out("rs_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Sole requester is re-granted after one IDLE cycle
        req = 4'b0001;
        cyc();
        exp_out("solo_start1", 4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b1;
        core_done  = 1'b1;
        cyc();
        exp_out("solo_done1", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b0;
        core_done  = 1'b0;
        cyc();
        exp_out("solo_gap", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc();
        exp_out("solo_start2", 4'b0001, 4'b0, 4'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b1;
        core_done  = 1'b1;
        cyc();
        exp_out("solo_done2", 4'b0001, 4'b0001, 4'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        core_ready = 1'b0;
        core_done  = 1'b0;
        req        = 4'b0;
        cyc();
        exp_out("solo_idle", 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
